// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch front end. Holds the PC, issues one
// request at a time to instruction memory and captures responses into an
// IF/ID register backed by a one-entry skid buffer.
// Optional build macro FETCH_PERF_CNT_EN adds saturating fetch/kill counters.
//
// state  | meaning
// S_BOOT | single idle cycle after reset release, no request
// S_REQ  | request pc (only while the skid buffer is empty)
// S_WAIT | one request outstanding, waiting for imem_rvalid
module fetch_pc_unit #(
  parameter int N = 8,
  parameter int DATA_W = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              branch_taken,
  input  logic [N-1:0]      branch_target,
  input  logic              stall_i,
  output logic              imem_req,
  output logic [N-1:0]      imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [N-1:0]      if_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [15:0]       perf_killed
`endif
);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT} state_t;

  state_t              state, state_nxt;
  logic [N-1:0]        pc, req_pc;
  logic                kill;
  logic                skid_valid;
  logic [DATA_W-1:0]   skid_instr;
  logic [N-1:0]        skid_pc;
  logic                grant, resp, deliver, drop;

  assign grant   = imem_req && imem_gnt;
  assign resp    = (state == S_WAIT) && imem_rvalid;
  // a response is dropped if it belongs to a killed request or a redirect
  // lands in the same cycle
  assign deliver = resp && !kill && !branch_taken;
  assign drop    = resp && !deliver;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_BOOT;
    else        state <= state_nxt;
  end

  // next-state and request outputs
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    imem_addr = pc;
    case (state)
      S_BOOT: state_nxt = S_REQ;
      S_REQ: begin
        imem_req = !skid_valid;
        if (!skid_valid && imem_gnt) state_nxt = S_WAIT;
      end
      S_WAIT: if (imem_rvalid) state_nxt = S_REQ;
      default: state_nxt = S_BOOT;
    endcase
  end

  // program counter, PC of the outstanding request, and kill tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      req_pc <= '0;
      kill   <= 1'b0;
    end else begin
      if (grant) req_pc <= pc;
      if (branch_taken)  pc <= branch_target;
      else if (grant)    pc <= pc + N'(4);
      // a request that is still in flight after this edge must be discarded;
      // a response arriving together with the redirect is already dropped
      if (branch_taken)  kill <= grant || ((state == S_WAIT) && !imem_rvalid);
      else if (resp)     kill <= 1'b0;
    end
  end

  // IF/ID register and skid buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (branch_taken) begin
      if_valid   <= 1'b0;
      skid_valid <= 1'b0;
    end else if (deliver) begin
      if (!if_valid || !stall_i) begin
        if_valid <= 1'b1;
        if_instr <= imem_rdata;
        if_pc    <= req_pc;
      end else begin
        skid_valid <= 1'b1;
        skid_instr <= imem_rdata;
        skid_pc    <= req_pc;
      end
    end else if (if_valid && !stall_i) begin
      if (skid_valid) begin
        if_instr   <= skid_instr;
        if_pc      <= skid_pc;
        skid_valid <= 1'b0;
      end else begin
        if_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // saturating counters of delivered and discarded responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_killed  <= '0;
    end else begin
      if (deliver && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
      if (drop && (perf_killed != '1))     perf_killed  <= perf_killed + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch front end. Holds the program counter and issues one-at-a-time requests to instruction memory.
- Captures returned instructions into an IF/ID output register with a one-entry skid buffer.
- Next-PC selection is sequential PC+4 or a redirect target. Redirects come from the execute stage's branch resolution.
- Sits between the branch unit (upstream redirect source) and decode (downstream consumer).

Parameters:
- N, 8, PC/address width in bits; PC arithmetic is modulo 2^N.
- DATA_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset (N bits).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- branch_taken  in  1  redirect pulse, sampled each cycle.
- branch_target  in  N  redirect PC, valid while branch_taken=1.
- stall_i  in  1  decode not accepting; IF/ID register must hold.
- imem_req  out  1  request valid.
- imem_addr  out  N  request address.
- imem_gnt  in  1  request accepted this cycle (only meaningful while imem_req=1).
- imem_rvalid  in  1  response valid; cannot be back-pressured.
- imem_rdata  in  DATA_W  response instruction.
- if_valid  out  1  IF/ID register holds a live instruction.
- if_instr  out  DATA_W  instruction.
- if_pc  out  N  PC of if_instr.

Behaviour:
- Reset (rst_n=0, async): pc=RESET_PC, state=S_BOOT, if_valid=0, if_instr=0, if_pc=0, skid empty, kill=0, imem_req=0, imem_addr=RESET_PC.
- FSM states:
  - S_BOOT: one idle cycle after reset release, no request; next S_REQ.
  - S_REQ: imem_req=1 and imem_addr=pc only when the skid buffer is empty, else imem_req=0. On imem_gnt: req_pc<=pc, pc<=pc+4 (wraps, e.g. 8'hFC -> 8'h00), next S_WAIT.
  - S_WAIT: imem_req=0. On imem_rvalid, the response is delivered or dropped per the rules below; next S_REQ. Exactly one outstanding request at any time.
- Response delivery (kill=0):
  - If !if_valid or !stall_i: if_instr<=imem_rdata, if_pc<=req_pc, if_valid<=1.
  - Otherwise write the response to the skid buffer.
- Consume: when if_valid && !stall_i and no new response arrives, if_valid<=0 unless the skid buffer is full, in which case skid moves to IF/ID and skid empties.
  - Skid buffer has priority over a new response. A new response cannot coincide with a full skid because issue is blocked while skid is full.
- Redirect (branch_taken=1), highest priority:
  - pc<=branch_target.
  - if_valid<=0 and skid buffer emptied, regardless of stall_i.
  - If a request is outstanding, or is granted in the same cycle, set kill=1.
  - A response arriving with kill=1 is discarded and clears kill.
  - Redirect in the same cycle as a response with kill=0: the response is discarded as well.
- Redirect in S_BOOT: pc takes the target; S_BOOT still lasts one cycle.
- Back-to-back redirects: the last target wins; kill stays set until one response is dropped.
- Latency: with a zero-wait memory (gnt same cycle, rvalid next cycle), if_valid rises 2 cycles after the grant; sustained throughput is 1 instruction per 2 cycles.
- Reset mid-transaction: all state cleared immediately. The memory response, if any, is ignored because state is not S_WAIT.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, add outputs:
  - perf_fetched (32 bits): counts responses delivered with kill=0.
  - perf_killed (16 bits): counts discarded responses.
- Counters are cleared by rst_n and saturate at their maximum value.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, zero-wait memory, stall_i=0 -> first imem_addr=0x00 two cycles after release; if_pc sequence 0x00,0x04,0x08 with matching if_instr.
- pc=0xFC, N=8 -> after grant, next imem_addr=0x00 (wrap).
- stall_i=1 held for 4 cycles while a response returns -> if_instr/if_pc hold; response parked in skid; imem_req=0; on stall release both instructions appear in order on consecutive cycles.
- branch_taken with target=0x40 while in S_WAIT -> returning response dropped, if_valid=0, next imem_addr=0x40, perf_killed=1 if enabled.
- branch_taken in the same cycle as imem_gnt for addr 0x10 -> response for 0x10 discarded; next request to the target.
- rst_n asserted during S_WAIT, then rvalid arrives -> outputs stay at reset values; fetch restarts at RESET_PC.
